// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences the shared ALU one-hot strobes for N iterations and owns the AC register
module alu_op_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [WIDTH-1:0] cmd_dr,
   input  logic             ac_load,
   input  logic [WIDTH-1:0] ac_load_val,
   output logic [WIDTH-1:0] alu_dr,
   output logic [WIDTH-1:0] alu_ac,
   input  logic [WIDTH-1:0] alu_out,
   output logic             op_add,
   output logic             op_drtac,
   output logic             op_sub,
   output logic             op_or,
   output logic             op_and,
   output logic             op_xor,
   output logic             op_com,
   output logic             op_shl,
   output logic             op_shr,
   output logic [WIDTH-1:0] ac,
   output logic             busy,
   output logic             done,
   output logic             err
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] ac_q;
   logic [WIDTH-1:0] dr_q;
   logic [CNT_W-1:0] rem_q;
   logic [8:0]       strobe_q;
   logic             done_q;
   logic             err_q;
   logic [8:0]       op_dec;
   logic             op_illegal;

   // Strobe bit order: ADD is bit 0 through SHR at bit 8; NOP and illegal codes decode to none.
   always_comb begin
      op_dec = '0;
      case (cmd_op)
         4'd1:    op_dec[0] = 1'b1;
         4'd2:    op_dec[1] = 1'b1;
         4'd3:    op_dec[2] = 1'b1;
         4'd4:    op_dec[3] = 1'b1;
         4'd5:    op_dec[4] = 1'b1;
         4'd6:    op_dec[5] = 1'b1;
         4'd7:    op_dec[6] = 1'b1;
         4'd8:    op_dec[7] = 1'b1;
         4'd9:    op_dec[8] = 1'b1;
         default: op_dec = '0;
      endcase
   end

   assign op_illegal = (cmd_op > 4'd9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ac_q     <= '0;
         dr_q     <= '0;
         rem_q    <= '0;
         strobe_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               if (ac_load) begin
                  ac_q <= ac_load_val;
               end
               // cmd_ready is high throughout IDLE, so cmd_valid alone marks an accept.
               if (cmd_valid) begin
                  dr_q  <= cmd_dr;
                  rem_q <= (cmd_cnt == '0) ? CNT_W'(1) : cmd_cnt;
                  if (|op_dec) begin
                     state_q  <= EXEC;
                     strobe_q <= op_dec;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     err_q   <= op_illegal;
                  end
               end
            end
            EXEC: begin
               ac_q  <= alu_out;
               rem_q <= rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_q  <= DONE;
                  strobe_q <= '0;
                  done_q   <= 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q  <= IDLE;
               strobe_q <= '0;
               done_q   <= 1'b0;
               err_q    <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign ac        = ac_q;
   assign alu_ac    = ac_q;
   assign alu_dr    = dr_q;
   assign op_add    = strobe_q[0];
   assign op_drtac  = strobe_q[1];
   assign op_sub    = strobe_q[2];
   assign op_or     = strobe_q[3];
   assign op_and    = strobe_q[4];
   assign op_xor    = strobe_q[5];
   assign op_com    = strobe_q[6];
   assign op_shl    = strobe_q[7];
   assign op_shr    = strobe_q[8];
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with directed commands
module tb_alu_op_sequencer;
   localparam int WIDTH = 16;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [3:0]       cmd_op = '0;
   logic [CNT_W-1:0] cmd_cnt = '0;
   logic [WIDTH-1:0] cmd_dr = '0;
   logic             ac_load = 1'b0;
   logic [WIDTH-1:0] ac_load_val = '0;
   logic [WIDTH-1:0] alu_dr, alu_ac, alu_out, ac;
   logic op_add, op_drtac, op_sub, op_or, op_and, op_xor, op_com, op_shl, op_shr;
   logic busy, done, err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [WIDTH-1:0] ac;
      logic             err;
      logic [8:0]       mask;
      int               n;
      int               cyc;
   } exp_t;
   exp_t sb[$];

   alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
      .cmd_dr(cmd_dr), .ac_load(ac_load), .ac_load_val(ac_load_val),
      .alu_dr(alu_dr), .alu_ac(alu_ac), .alu_out(alu_out),
      .op_add(op_add), .op_drtac(op_drtac), .op_sub(op_sub), .op_or(op_or), .op_and(op_and),
      .op_xor(op_xor), .op_com(op_com), .op_shl(op_shl), .op_shr(op_shr),
      .ac(ac), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Combinational ALU standing in for the shared datapath.
   always_comb begin
      alu_out = alu_ac;
      if (op_add)   alu_out = alu_ac + alu_dr;
      if (op_drtac) alu_out = alu_dr;
      if (op_sub)   alu_out = alu_ac - alu_dr;
      if (op_or)    alu_out = alu_ac | alu_dr;
      if (op_and)   alu_out = alu_ac & alu_dr;
      if (op_xor)   alu_out = alu_ac ^ alu_dr;
      if (op_com)   alu_out = ~alu_ac;
      if (op_shl)   alu_out = alu_ac << 1;
      if (op_shr)   alu_out = alu_ac >> 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: accumulates strobe activity per command and scores each done pulse.
   int         nstrb = 0;
   logic [8:0] mask_acc = '0;
   logic       multi = 1'b0;
   always @(negedge clk) begin
      logic [8:0] sv;
      exp_t e;
      sv = {op_shr, op_shl, op_com, op_xor, op_and, op_or, op_sub, op_drtac, op_add};
      if (!rst_n) begin
         nstrb = 0; mask_acc = '0; multi = 1'b0;
      end else begin
         if (sv != '0) begin
            nstrb++;
            mask_acc = mask_acc | sv;
            if ($countones(sv) > 1) multi = 1'b1;
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("done_ac", 32'(ac), 32'(e.ac));
               check("done_err", 32'(err), 32'(e.err));
               check("done_cycle", 32'(cyc), 32'(e.cyc));
               check("strobe_mask", 32'(mask_acc), 32'(e.mask));
               check("strobe_cycles", 32'(nstrb), 32'(e.n));
               check("strobe_onehot", 32'(multi), 32'd0);
            end
            nstrb = 0; mask_acc = '0; multi = 1'b0;
         end else if (err) begin
            check("err_without_done", 32'd1, 32'd0);
         end
      end
   end

   task automatic do_cmd(input logic [3:0] op, input int cnt, input logic [WIDTH-1:0] dr,
                         input logic ld, input logic [WIDTH-1:0] ldv,
                         input logic [WIDTH-1:0] eac, input logic eerr, input logic [8:0] emask,
                         input int en, output int acc);
      int w;
      exp_t e;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_cnt = CNT_W'(cnt); cmd_dr = dr;
      ac_load = ld; ac_load_val = ldv;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      acc = -1;
      if (!cmd_ready) begin
         check("accept_timeout", 32'd1, 32'd0);
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         e.ac = eac; e.err = eerr; e.mask = emask; e.n = en; e.cyc = acc + en;
         sb.push_back(e);
      end
      cmd_valid = 1'b0; ac_load = 1'b0;
   endtask

   initial begin
      int a, a1, a2, w;
      #2;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ac", 32'(ac), 32'd0);
      check("rst_alu_dr", 32'(alu_dr), 32'd0);
      check("rst_done_err", 32'({done, err}), 32'd0);
      check("rst_strobes", 32'({op_add, op_drtac, op_sub, op_or, op_and, op_xor, op_com, op_shl, op_shr}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_cmd(4'd3, 1, 16'h1111, 1'b1, 16'h3333, 16'h2222, 1'b0, 9'h004, 1, a);
      do_cmd(4'd8, 4, 16'h0000, 1'b1, 16'h1111, 16'h1110, 1'b0, 9'h080, 4, a);
      do_cmd(4'hF, 2, 16'h0000, 1'b0, 16'h0000, 16'h1110, 1'b1, 9'h000, 0, a);

      // SHR x3 with a second command and ac_load held while busy.
      do_cmd(4'd9, 3, 16'h0000, 1'b0, 16'h0000, 16'h0222, 1'b0, 9'h100, 3, a1);
      cmd_valid = 1'b1; cmd_op = 4'd6; cmd_cnt = 4'd1; cmd_dr = 16'h00FF;
      ac_load = 1'b1; ac_load_val = 16'hBEEF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      do_cmd(4'd6, 1, 16'h00FF, 1'b1, 16'hBEEF, 16'hBE10, 1'b0, 9'h020, 1, a2);
      check("held_accept_cycle", 32'(a2), 32'(a1 + 5));

      do_cmd(4'd1, 0, 16'h1111, 1'b1, 16'h1111, 16'h2222, 1'b0, 9'h001, 1, a);
      do_cmd(4'd0, 5, 16'h0000, 1'b0, 16'h0000, 16'h2222, 1'b0, 9'h000, 0, a);
      do_cmd(4'd1, 15, 16'h0001, 1'b1, 16'h0000, 16'h000F, 1'b0, 9'h001, 15, a);
      do_cmd(4'd7, 1, 16'h0000, 1'b0, 16'h0000, 16'hFFF0, 1'b0, 9'h040, 1, a);
      do_cmd(4'd2, 2, 16'h1234, 1'b0, 16'h0000, 16'h1234, 1'b0, 9'h002, 2, a);
      do_cmd(4'd4, 1, 16'h0F00, 1'b0, 16'h0000, 16'h1F34, 1'b0, 9'h008, 1, a);
      do_cmd(4'd5, 1, 16'h00FF, 1'b0, 16'h0000, 16'h0034, 1'b0, 9'h010, 1, a);
      do_cmd(4'd1, 1, 16'h0002, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 9'h001, 1, a);
      do_cmd(4'd3, 1, 16'h0001, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 9'h004, 1, a);
      do_cmd(4'hA, 0, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 9'h000, 0, a);
      do_cmd(4'd9, 1, 16'h0000, 1'b1, 16'h8001, 16'h4000, 1'b0, 9'h100, 1, a);

      // Reset in the middle of SHR x8: aborts at once with no done.
      do_cmd(4'd9, 8, 16'h0000, 1'b1, 16'h8000, 16'h0000, 1'b0, 9'h100, 8, a);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("abort_strobes", 32'({op_add, op_drtac, op_sub, op_or, op_and, op_xor, op_com, op_shl, op_shr}), 32'd0);
      check("abort_ac", 32'(ac), 32'd0);
      check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      do_cmd(4'd1, 2, 16'h0005, 1'b0, 16'h0000, 16'h000A, 1'b0, 9'h001, 2, a);

      w = 0;
      while ((sb.size() != 0 || busy) && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
